// File: rtl/bp_fe_bp_pkg.sv
// Shared types for the gshare front-end predictor: FSM states and in-flight queue entries.
package bp_fe_bp_pkg;

  // In-flight entries carry the widest supported table index; narrower tables zero-fill the top.
  localparam int bp_idx_max_width_lp = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic [bp_idx_max_width_lp-1:0] idx;
    logic                           pred;
  } bp_inflight_entry_s;

endpackage

// File: rtl/bp_fe_bp_inflight_fifo.sv
// Queue of unresolved predictions; pointers carry an extra wrap bit to tell full from empty.
module bp_fe_bp_inflight_fifo
  import bp_fe_bp_pkg::*;
#(
  parameter  int els_p    = 4,
  localparam int ptr_w_lp = $clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                push_i,
  input  bp_inflight_entry_s  entry_i,
  input  logic                pop_i,
  input  logic                clear_i,
  output bp_inflight_entry_s  head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [ptr_w_lp-1:0] tail_o
);

  logic [ptr_w_lp:0]  head_r, tail_r, head_n, tail_n;
  bp_inflight_entry_s mem_r [els_p];

  // Clearing collapses the tail onto the (possibly just advanced) head.
  assign head_n = head_r + (ptr_w_lp+1)'(pop_i);
  assign tail_n = clear_i ? head_n : tail_r + (ptr_w_lp+1)'(push_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      head_r <= head_n;
      tail_r <= tail_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_r[tail_r[ptr_w_lp-1:0]] <= entry_i;
  end

  assign head_o  = mem_r[head_r[ptr_w_lp-1:0]];
  assign empty_o = (head_r == tail_r);
  assign full_o  = (head_r[ptr_w_lp] != tail_r[ptr_w_lp])
                && (head_r[ptr_w_lp-1:0] == tail_r[ptr_w_lp-1:0]);
  assign tail_o  = tail_r[ptr_w_lp-1:0];

endmodule

// File: rtl/bp_fe_bp_gshare_spec.sv
// Gshare branch predictor with speculative global history and in-order resolve/recovery.
//   state | meaning
//   INIT  | sweep counter table to weakly-not-taken, one entry per cycle
//   RUN   | accept predictions and resolves
module bp_fe_bp_gshare_spec
  import bp_fe_bp_pkg::*;
#(
  parameter  int bht_idx_width_p   = 8,
  parameter  int ghist_width_p     = 8,
  parameter  int bp_cnt_sat_bits_p = 2,
  parameter  int inflight_els_p    = 4,
  localparam int tag_w_lp          = $clog2(inflight_els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       ready_o,
  input  logic                       r_v_i,
  output logic                       r_ready_o,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_o,
  output logic [tag_w_lp-1:0]        tag_o,
  input  logic                       w_v_i,
  input  logic                       taken_i,
  output logic                       mispredict_o,
  input  logic                       flush_i
);

  localparam int bht_els_lp = 1 << bht_idx_width_p;
  localparam logic [bp_cnt_sat_bits_p-1:0] cnt_weak_lp =
    bp_cnt_sat_bits_p'((1 << (bp_cnt_sat_bits_p-1)) - 1);
  localparam logic [bp_cnt_sat_bits_p-1:0] cnt_max_lp = '1;

  bp_state_e                  state_r, state_n;
  logic [bht_idx_width_p-1:0] sweep_idx_r;
  logic                       run;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= INIT;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      INIT:    if (sweep_idx_r == '1) state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = INIT;
    endcase
  end

  always_comb begin
    run     = (state_r == RUN);
    ready_o = run;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)           sweep_idx_r <= '0;
    else if (state_r == INIT) sweep_idx_r <= sweep_idx_r + 1'b1;
  end

  logic [bp_cnt_sat_bits_p-1:0] bht_r [bht_els_lp];
  logic [ghist_width_p-1:0]     gh_spec_r, gh_commit_r, gh_commit_n;
  logic [bht_idx_width_p-1:0]   read_idx, upd_idx;
  logic [bp_cnt_sat_bits_p-1:0] upd_cnt, upd_val;
  logic                         fifo_full, fifo_empty;
  logic                         accept, resolve, mispred, recover, push;
  logic                         mispredict_r;
  logic                         unused_idx_bits;
  bp_inflight_entry_s           push_entry, head_entry;

  assign read_idx  = idx_r_i ^ bht_idx_width_p'(gh_spec_r);
  assign predict_o = run & r_v_i & (bht_r[read_idx] > cnt_weak_lp);
  assign r_ready_o = run & ~fifo_full;

  assign accept  = r_v_i & r_ready_o;
  assign resolve = run & w_v_i & ~fifo_empty;
  assign mispred = resolve & (taken_i != head_entry.pred);
  assign recover = mispred | (run & flush_i);
  // A recovery in the same cycle discards the new prediction entirely.
  assign push    = accept & ~recover;

  always_comb begin
    push_entry                           = '0;
    push_entry.idx[bht_idx_width_p-1:0]  = read_idx;
    push_entry.pred                      = predict_o;
  end

  bp_fe_bp_inflight_fifo #(.els_p(inflight_els_p)) inflight_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .entry_i   (push_entry),
    .pop_i     (resolve),
    .clear_i   (recover),
    .head_o    (head_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .tail_o    (tag_o)
  );

  assign unused_idx_bits = ^head_entry.idx;
  assign upd_idx = head_entry.idx[bht_idx_width_p-1:0];
  assign upd_cnt = bht_r[upd_idx];

  always_comb begin
    upd_val = upd_cnt;
    if (taken_i) begin
      if (upd_cnt != cnt_max_lp) upd_val = upd_cnt + 1'b1;
    end else begin
      if (upd_cnt != '0) upd_val = upd_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_r == INIT) bht_r[sweep_idx_r] <= cnt_weak_lp;
    else if (resolve)    bht_r[upd_idx]     <= upd_val;
  end

  assign gh_commit_n = resolve ? ghist_width_p'({gh_commit_r, taken_i}) : gh_commit_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gh_spec_r    <= '0;
      gh_commit_r  <= '0;
      mispredict_r <= 1'b0;
    end else begin
      gh_commit_r  <= gh_commit_n;
      mispredict_r <= mispred;
      if (recover)   gh_spec_r <= gh_commit_n;
      else if (push) gh_spec_r <= ghist_width_p'({gh_spec_r, predict_o});
    end
  end

  assign mispredict_o = mispredict_r;

endmodule

// File: tb/tb_bp_fe_bp_gshare_spec.sv
// Self-checking bench for the gshare predictor against a queue/array reference model.
module tb_bp_fe_bp_gshare_spec;

  localparam int IW = 4;
  localparam int GW = 4;
  localparam int CW = 2;
  localparam int QE = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          r_v_i = 1'b0, w_v_i = 1'b0, taken_i = 1'b0, flush_i = 1'b0;
  logic [IW-1:0] idx_r_i = '0;
  logic          ready_o, r_ready_o, predict_o, mispredict_o;
  logic [1:0]    tag_o;

  always #5 clk_i = ~clk_i;

  bp_fe_bp_gshare_spec #(
    .bht_idx_width_p(IW), .ghist_width_p(GW),
    .bp_cnt_sat_bits_p(CW), .inflight_els_p(QE)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .ready_o(ready_o),
    .r_v_i(r_v_i), .r_ready_o(r_ready_o), .idx_r_i(idx_r_i),
    .predict_o(predict_o), .tag_o(tag_o), .w_v_i(w_v_i),
    .taken_i(taken_i), .mispredict_o(mispredict_o), .flush_i(flush_i)
  );

  typedef struct {
    int idx;
    int pred;
  } m_ent_t;

  int     tests = 0;
  int     fails = 0;
  int     cnt_m [16];
  m_ent_t q_m [$];
  int     gh_spec_m, gh_commit_m, head_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) cnt_m[i] = 1;
    q_m.delete();
    gh_spec_m   = 0;
    gh_commit_m = 0;
    head_m      = 0;
  endtask

  // One RUN-mode cycle: drive, check combinational outputs, clock, update model, check pulse.
  task automatic step(input bit rv, input int idx, input bit wv, input bit tk, input bit fl);
    int     ri, pred, rdy;
    bit     acc, res, mis;
    m_ent_t e;
    r_v_i = rv; idx_r_i = idx[IW-1:0]; w_v_i = wv; taken_i = tk; flush_i = fl;
    #1;
    ri   = (idx ^ gh_spec_m) & 15;
    pred = (rv && cnt_m[ri] > 1) ? 1 : 0;
    rdy  = (q_m.size() < QE) ? 1 : 0;
    chk("ready_o", ready_o, 1);
    chk("r_ready_o", r_ready_o, rdy);
    chk("predict_o", predict_o, pred);
    chk("tag_o", tag_o, (head_m + q_m.size()) % QE);
    @(posedge clk_i); #1;
    acc = rv && (rdy == 1);
    res = wv && (q_m.size() > 0);
    mis = 1'b0;
    if (res) begin
      e = q_m.pop_front();
      head_m = (head_m + 1) % QE;
      if (tk) cnt_m[e.idx] = (cnt_m[e.idx] == 3) ? 3 : cnt_m[e.idx] + 1;
      else    cnt_m[e.idx] = (cnt_m[e.idx] == 0) ? 0 : cnt_m[e.idx] - 1;
      gh_commit_m = ((gh_commit_m << 1) | int'(tk)) & 15;
      mis = (int'(tk) != e.pred);
    end
    if (mis || fl) begin
      q_m.delete();
      gh_spec_m = gh_commit_m;
    end else if (acc) begin
      q_m.push_back('{idx: ri, pred: pred});
      gh_spec_m = ((gh_spec_m << 1) | pred) & 15;
    end
    chk("mispredict_o", mispredict_o, mis);
  endtask

  // Called just after reset release; INIT must last exactly 16 edges while ignoring inputs.
  task automatic init_wait();
    for (int k = 1; k <= 16; k++) begin
      r_v_i = 1'($urandom); w_v_i = 1'($urandom); flush_i = 1'($urandom);
      taken_i = 1'($urandom); idx_r_i = IW'($urandom);
      #1;
      chk("init_r_ready", r_ready_o, 0);
      chk("init_predict", predict_o, 0);
      chk("init_tag", tag_o, 0);
      chk("init_mispredict", mispredict_o, 0);
      @(posedge clk_i); #1;
      chk("init_ready", ready_o, (k == 16) ? 1 : 0);
    end
    r_v_i = 1'b0; w_v_i = 1'b0; flush_i = 1'b0; taken_i = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_ready", ready_o, 0);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_mispredict", mispredict_o, 0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    init_wait();

    // Fill the queue, observe back-pressure, free one slot.
    for (int i = 0; i < 4; i++) step(1, 8 + i, 0, 0, 0);
    step(1, 12, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 12, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Three not-taken predictions, oldest resolves taken.
    for (int i = 0; i < 3; i++) step(1, 12 + i, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);

    // Train read index 5 toward taken.
    for (int i = 0; i < 3; i++) begin
      step(1, 5 ^ gh_spec_m, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1);
    end
    step(1, 5 ^ gh_spec_m, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Flush with two in flight, then the next accept lands at the head slot.
    step(1, 3, 0, 0, 0);
    step(1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 9, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step(($urandom % 10) < 7, int'($urandom % 16), ($urandom % 10) < 4,
           1'($urandom), ($urandom % 20) == 0);

    // Reset mid-RUN, then again mid-INIT at sweep index 7.
    reset_n_i = 1'b0;
    #1;
    chk("midrun_rst_ready", ready_o, 0);
    chk("midrun_rst_tag", tag_o, 0);
    model_reset();
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    repeat (7) @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("midinit_rst_ready", ready_o, 0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    init_wait();

    for (int i = 0; i < 100; i++)
      step(($urandom % 10) < 7, int'($urandom % 16), ($urandom % 10) < 4,
           1'($urandom), ($urandom % 20) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
